// File: rtl/gate_checker_pkg.sv
// Shared constants for gate_checker: FSM state encodings, res bit positions and result width.
package gate_checker_pkg;

  localparam int RES_W = 6;

  // Bit positions inside res / fail_mask / expected vectors
  localparam int RES_AND1 = 5;
  localparam int RES_AND2 = 4;
  localparam int RES_OR1  = 3;
  localparam int RES_OR2  = 2;
  localparam int RES_NOT1 = 1;
  localparam int RES_NOT2 = 0;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

endpackage

// File: rtl/gate_checker_ref.sv
// gate_ref_model: combinational golden model of the six gates under test.
import gate_checker_pkg::*;

module gate_ref_model (
  input  logic             a,
  input  logic             b,
  output logic [RES_W-1:0] exp
);

  always_comb begin
    exp           = '0;
    exp[RES_AND1] = a & b;
    exp[RES_AND2] = a & b;
    exp[RES_OR1]  = a | b;
    exp[RES_OR2]  = a | b;
    exp[RES_NOT1] = ~a;
    exp[RES_NOT2] = ~a;
  end

endmodule

// File: rtl/gate_checker.sv
// gate_checker: runs NUM_VECTORS gate result vectors against a reference model and reports errors.
// Optional feature: define GATE_CHECKER_STICKY_EN to build the sticky per-gate fail_mask register.
import gate_checker_pkg::*;

module gate_checker #(
  parameter int NUM_VECTORS = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             a,
  input  logic             b,
  input  logic [RES_W-1:0] res,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [RES_W-1:0] fail_mask
);

  // Handshake: a vector transfers on a rising edge where in_valid && in_ready;
  // in_ready depends only on state, never on in_valid.
  state_t           state;
  logic [7:0]       acc_cnt;
  logic [RES_W-1:0] exp_res;
  logic [RES_W-1:0] mism;
  logic             accept;
  logic             run_start;

  gate_ref_model u_ref (
    .a   (a),
    .b   (b),
    .exp (exp_res)
  );

  assign mism      = res ^ exp_res;
  assign in_ready  = (state == RUN);
  assign accept    = in_valid && in_ready;
  assign run_start = start && (state != RUN);
  assign done      = (state == DONE);
  assign pass      = done && (err_count == '0);

  // acc_cnt tracks run length independently of CNT_W so a narrow vec_count cannot stall the run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      acc_cnt       <= '0;
      err_count     <= '0;
      vec_count     <= '0;
      first_err_idx <= '1;
    end else if (run_start) begin
      state         <= RUN;
      acc_cnt       <= '0;
      err_count     <= '0;
      vec_count     <= '0;
      first_err_idx <= '1;
    end else if (accept) begin
      acc_cnt <= acc_cnt + 8'd1;
      if (vec_count != '1)
        vec_count <= vec_count + 1'b1;
      if (mism != '0) begin
        // err_count is still zero only before the first mismatch of this run
        if (err_count == '0)
          first_err_idx <= vec_count;
        if (err_count != '1)
          err_count <= err_count + 1'b1;
      end
      if (acc_cnt == 8'(NUM_VECTORS - 1))
        state <= DONE;
    end
  end

`ifdef GATE_CHECKER_STICKY_EN
  logic [RES_W-1:0] mask_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      mask_q <= '0;
    else if (run_start)
      mask_q <= '0;
    else if (accept)
      mask_q <= mask_q | mism;
  end

  assign fail_mask = mask_q;
`else
  assign fail_mask = '0;
`endif

endmodule

// File: tb/tb_gate_checker.sv
// Self-checking bench for gate_checker: scoreboard of post-accept counter values plus a saturation instance.
module tb_gate_checker;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic       in_ready;
  logic       a;
  logic       b;
  logic [5:0] res;
  logic       done;
  logic       pass;
  logic [7:0] err_count;
  logic [7:0] vec_count;
  logic [7:0] first_err_idx;
  logic [5:0] fail_mask;

  logic       s_start;
  logic       s_valid;
  logic       s_ready;
  logic       s_a;
  logic       s_b;
  logic [5:0] s_res;
  logic       s_done;
  logic       s_pass;
  logic [3:0] s_err;
  logic [3:0] s_vec;
  logic [3:0] s_first;
  logic [5:0] s_mask;

  gate_checker dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .a             (a),
    .b             (b),
    .res           (res),
    .done          (done),
    .pass          (pass),
    .err_count     (err_count),
    .vec_count     (vec_count),
    .first_err_idx (first_err_idx),
    .fail_mask     (fail_mask)
  );

  gate_checker #(.NUM_VECTORS(255), .CNT_W(4)) u_sat (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (s_start),
    .in_valid      (s_valid),
    .in_ready      (s_ready),
    .a             (s_a),
    .b             (s_b),
    .res           (s_res),
    .done          (s_done),
    .pass          (s_pass),
    .err_count     (s_err),
    .vec_count     (s_vec),
    .first_err_idx (s_first),
    .fail_mask     (s_mask)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard and model state
  logic [29:0] exp_q[$];
  int          n_checks;
  int          n_errors;
  int          n_acc;
  int          s_acc;
  logic [1:0]  m_state;  // 0 idle, 1 run, 2 done
  logic [7:0]  m_vec;
  logic [7:0]  m_err;
  logic [7:0]  m_first;
  logic [5:0]  m_mask;

  function automatic logic [5:0] gold(input logic ia, input logic ib);
    return {ia & ib, ia & ib, ia | ib, ia | ib, ~ia, ~ia};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, expv, $time);
    end
  endtask

  task automatic model_clear();
    m_vec   = 8'd0;
    m_err   = 8'd0;
    m_first = 8'hFF;
    m_mask  = 6'd0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".in_ready"}, in_ready, m_state == 2'd1);
    check({tag, ".done"}, done, m_state == 2'd2);
    check({tag, ".pass"}, pass, (m_state == 2'd2) && (m_err == 8'd0));
    check({tag, ".err_count"}, err_count, m_err);
    check({tag, ".vec_count"}, vec_count, m_vec);
    check({tag, ".first_err_idx"}, first_err_idx, m_first);
    check({tag, ".fail_mask"}, fail_mask, m_mask);
  endtask

  // driver tasks
  task automatic pulse_start();
    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b0;
    if (m_state != 2'd1) begin
      model_clear();
      m_state = 2'd1;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    check("start.in_ready", in_ready, 1'b1);
    check("start.vec_count", vec_count, m_vec);
    check("start.err_count", err_count, m_err);
  endtask

  task automatic send(input logic va, input logic ia, input logic ib, input logic [5:0] r);
    logic        acc;
    logic [5:0]  mm;
    logic [29:0] e;
    @(negedge clk);
    in_valid = va;
    a        = ia;
    b        = ib;
    res      = r;
    check("send.in_ready", in_ready, m_state == 2'd1);
    acc = va && (m_state == 2'd1);
    if (acc) begin
      mm = r ^ gold(ia, ib);
      if (mm != 6'd0) begin
        if (m_err == 8'd0) m_first = m_vec;
        if (m_err != 8'hFF) m_err = m_err + 8'd1;
      end
`ifdef GATE_CHECKER_STICKY_EN
      m_mask = m_mask | mm;
`endif
      m_vec = m_vec + 8'd1;
      if (m_vec == 8'd4) m_state = 2'd2;
      exp_q.push_back({m_vec, m_err, m_first, m_mask});
      n_acc++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (acc && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("acc.vec_count", vec_count, e[29:22]);
      check("acc.err_count", err_count, e[21:14]);
      check("acc.first_err_idx", first_err_idx, e[13:6]);
      check("acc.fail_mask", fail_mask, e[5:0]);
    end
    check("send.done", done, m_state == 2'd2);
  endtask

  task automatic send_good(input logic ia, input logic ib);
    send(1'b1, ia, ib, gold(ia, ib));
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_state = 2'd0;
    model_clear();
    exp_q.delete();
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic ta, tb;
    n_checks = 0;
    n_errors = 0;
    n_acc    = 0;
    s_acc    = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    a        = 1'b0;
    b        = 1'b0;
    res      = 6'd0;
    s_start  = 1'b0;
    s_valid  = 1'b0;
    s_a      = 1'b0;
    s_b      = 1'b0;
    s_res    = 6'd0;
    m_state  = 2'd0;
    model_clear();
    repeat (2) @(negedge clk);
    check_outputs("por");
    rst_n = 1'b1;

    // IDLE ignores vectors until start
    send_good(1'b1, 1'b1);
    check_outputs("idle");

    // correct run
    pulse_start();
    send_good(1'b0, 1'b0);
    send_good(1'b0, 1'b1);
    send_good(1'b1, 1'b0);
    send_good(1'b1, 1'b1);
    check_outputs("good_run");
    check("good_run.pass_lit", pass, 1'b1);

    // injected fault on vector 2
    pulse_start();
    send_good(1'b0, 1'b0);
    send_good(1'b0, 1'b1);
    send(1'b1, 1'b1, 1'b0, 6'b001111);
    send_good(1'b1, 1'b1);
    check_outputs("fault_run");
    check("fault_run.first_lit", first_err_idx, 8'd2);
`ifdef GATE_CHECKER_STICKY_EN
    check("fault_run.mask_lit", fail_mask, 6'b000011);
`else
    check("fault_run.mask_lit", fail_mask, 6'b000000);
`endif

    // DONE holds outputs with no start
    repeat (3) send_good(1'b1, 1'b1);
    check_outputs("done_hold");

    // throttled in_valid
    pulse_start();
    n_acc = 0;
    for (int i = 0; i < 12; i++) begin
      ta = 1'($urandom_range(0, 1));
      tb = 1'($urandom_range(0, 1));
      send((i % 2) == 0, ta, tb, gold(ta, tb));
    end
    check("throttle.accepts", n_acc, 4);
    check_outputs("throttle");

    // restart from DONE, then start during RUN is ignored
    pulse_start();
    send_good(1'b0, 1'b1);
    pulse_start();
    check("run_start.vec_count", vec_count, 8'd1);
    send_good(1'b1, 1'b0);
    send(1'b1, 1'b0, 1'b0, 6'b100000);
    send_good(1'b1, 1'b1);
    check_outputs("restart");

    // reset mid-run, then a full new run
    pulse_start();
    send_good(1'b1, 1'b1);
    send_good(1'b0, 1'b0);
    apply_reset();
    send_good(1'b1, 1'b0);
    check_outputs("post_reset_idle");
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      ta = 1'($urandom_range(0, 1));
      tb = 1'($urandom_range(0, 1));
      send(1'b1, ta, tb, gold(ta, tb) ^ 6'(($urandom_range(0, 3) == 0) ? 6'b010000 : 6'b0));
    end
    check_outputs("post_reset_run");

    // saturation instance: every vector wrong
    @(negedge clk);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (s_ready) s_acc++;
      s_a   = 1'($urandom_range(0, 1));
      s_b   = 1'($urandom_range(0, 1));
      s_res = ~gold(s_a, s_b);
      @(negedge clk);
      if (s_acc == 20) check("sat.err_mid", s_err, 4'hF);
    end
    s_valid = 1'b0;
    check("sat.accepts", s_acc, 255);
    check("sat.err_count", s_err, 4'hF);
    check("sat.done", s_done, 1'b1);
    check("sat.pass", s_pass, 1'b0);
    check("sat.first_err_idx", s_first, 4'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
